// File: rtl/mem_wb_stage.sv
// MIPS memory-access stage fused with the M/W pipeline register; owns the byte-lane data memory.
// Optional store trace compiled in when DM_DISPLAY_EN is defined.
module mem_wb_stage #(
    parameter int DM_WORDS = 1024,
    parameter int DM_AW    = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR_M,
    input  logic [31:0] pc_M,
    input  logic [31:0] pc4_M,
    input  logic [31:0] ALUout_M,
    input  logic [31:0] WD_M,
    output logic [31:0] IR_W,
    output logic [31:0] pc_W,
    output logic [31:0] pc4_W,
    output logic [31:0] ALUout_W,
    output logic [31:0] DMout_W
);

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;

    logic [31:0]      dm_q [DM_WORDS];
    logic [5:0]       op_s;
    logic [1:0]       boff_s;
    logic [DM_AW-1:0] widx_s;
    logic [31:0]      rd_word_s;
    logic             is_store_s;
    logic [31:0]      merged_word_s;
    logic [15:0]      half_s;
    logic [7:0]       byte_s;
    logic [31:0]      load_ext_d;

    logic [31:0] ir_q, pc_q, pc4_q, alu_q, dmout_q;
    logic [31:0] ir_d, pc_d, pc4_d, alu_d;

    // High address bits are dropped, so accesses wrap modulo the memory size.
    assign op_s      = IR_M[31:26];
    assign boff_s    = ALUout_M[1:0];
    assign widx_s    = ALUout_M[DM_AW+1:2];
    assign rd_word_s = dm_q[widx_s];

    // Store decode and lane merge of the new data into the current word
    always_comb begin
        is_store_s    = 1'b0;
        merged_word_s = rd_word_s;
        case (op_s)
            OP_SW: begin
                is_store_s    = 1'b1;
                merged_word_s = WD_M;
            end
            OP_SH: begin
                is_store_s = 1'b1;
                if (boff_s[1]) begin
                    merged_word_s[31:16] = WD_M[15:0];
                end else begin
                    merged_word_s[15:0] = WD_M[15:0];
                end
            end
            OP_SB: begin
                is_store_s = 1'b1;
                case (boff_s)
                    2'd0:    merged_word_s[7:0]   = WD_M[7:0];
                    2'd1:    merged_word_s[15:8]  = WD_M[7:0];
                    2'd2:    merged_word_s[23:16] = WD_M[7:0];
                    2'd3:    merged_word_s[31:24] = WD_M[7:0];
                    default: merged_word_s        = rd_word_s;
                endcase
            end
            default: begin
                is_store_s    = 1'b0;
                merged_word_s = rd_word_s;
            end
        endcase
    end

    // Load lane select and sign/zero extension
    always_comb begin
        if (boff_s[1]) begin
            half_s = rd_word_s[31:16];
        end else begin
            half_s = rd_word_s[15:0];
        end
        case (boff_s)
            2'd0:    byte_s = rd_word_s[7:0];
            2'd1:    byte_s = rd_word_s[15:8];
            2'd2:    byte_s = rd_word_s[23:16];
            2'd3:    byte_s = rd_word_s[31:24];
            default: byte_s = 8'h00;
        endcase
        case (op_s)
            OP_LW:   load_ext_d = rd_word_s;
            OP_LH:   load_ext_d = {{16{half_s[15]}}, half_s};
            OP_LHU:  load_ext_d = {16'h0000, half_s};
            OP_LB:   load_ext_d = {{24{byte_s[7]}}, byte_s};
            OP_LBU:  load_ext_d = {24'h000000, byte_s};
            default: load_ext_d = 32'h0000_0000;
        endcase
    end

    assign ir_d  = IR_M;
    assign pc_d  = pc_M;
    assign pc4_d = pc4_M;
    assign alu_d = ALUout_M;

    // Data memory: cleared by reset, one merged word written per store
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DM_WORDS; i++) begin
                dm_q[i] <= 32'h0000_0000;
            end
        end else if (is_store_s) begin
            dm_q[widx_s] <= merged_word_s;
        end
    end

    // M/W pipeline register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_q    <= 32'h0000_0000;
            pc_q    <= 32'h0000_0000;
            pc4_q   <= 32'h0000_0000;
            alu_q   <= 32'h0000_0000;
            dmout_q <= 32'h0000_0000;
        end else begin
            ir_q    <= ir_d;
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            alu_q   <= alu_d;
            dmout_q <= load_ext_d;
        end
    end

`ifdef DM_DISPLAY_EN
    // Store trace
    always @(posedge clk) begin
        if (!reset && is_store_s) begin
            $display("%d@%h: *%h <= %h", $time, pc_M, {ALUout_M[31:2], 2'b00}, merged_word_s);
        end
    end
`endif

    assign IR_W     = ir_q;
    assign pc_W     = pc_q;
    assign pc4_W    = pc4_q;
    assign ALUout_W = alu_q;
    assign DMout_W  = dmout_q;

endmodule
